// File: rtl/imem_port_arbiter_pkg.sv
// Shared constants and helpers for the instruction ROM port arbiter.
// Port indices, default widths and byte-to-word address conversion.
package imem_port_arbiter_pkg;

    localparam int ADDR_W_D = 32;
    localparam int DATA_W_D = 32;
    localparam int MEM_AW_D = 8;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_LD = 1'b1;

    typedef struct packed {
        logic valid;
        logic tag;
    } inflight_t;

    // Callers truncate the result to the ROM word-address width.
    function automatic logic [63:0] byte_to_word(input logic [63:0] a);
        return {2'b00, a[63:2]};
    endfunction

endpackage

// File: rtl/imem_port_arbiter_rsp_slot.sv
// One-entry response buffer with valid/ready drain.
// Clear beats write, write beats drain.
module imem_port_arbiter_rsp_slot
    import imem_port_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_D
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_rd,
    input  logic              i_clr,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_wr) begin
            r_valid <= 1'b1;
            r_data  <= i_wdata;
        end else if (i_rd) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/imem_port_arbiter.sv
// Round-robin arbiter sharing one registered-address ROM between
// the fetch (IF) and load (LD) ports, one read in flight at a time.
module imem_port_arbiter
    import imem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_D,
    parameter int DATA_W = DATA_W_D,
    parameter int MEM_AW = MEM_AW_D
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [DATA_W-1:0] if_rsp_data,
    input  logic              if_flush,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_rsp_valid,
    input  logic              ld_rsp_ready,
    output logic [DATA_W-1:0] ld_rsp_data,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata
);

    inflight_t         r_infl;
    logic              r_rr_last;
    logic [MEM_AW-1:0] r_hold;

    logic [MEM_AW-1:0] w_if_word;
    logic [MEM_AW-1:0] w_ld_word;
    logic              w_if_infl;
    logic              w_ld_infl;
    logic              w_if_elig;
    logic              w_ld_elig;
    logic              w_if_cand;
    logic              w_ld_cand;
    logic              w_gnt_if;
    logic              w_gnt_ld;
    logic              w_if_wr;
    logic              w_ld_wr;

    assign w_if_word = MEM_AW'(byte_to_word(64'(if_req_addr)));
    assign w_ld_word = MEM_AW'(byte_to_word(64'(ld_req_addr)));

    assign w_if_infl = r_infl.valid && (r_infl.tag == PORT_IF);
    assign w_ld_infl = r_infl.valid && (r_infl.tag == PORT_LD);

    // A port may only be granted if its slot is guaranteed free on landing.
    assign w_if_elig = !iRST && !if_flush && !w_if_infl
                     && (!if_rsp_valid || if_rsp_ready);
    assign w_ld_elig = !iRST && !w_ld_infl
                     && (!ld_rsp_valid || ld_rsp_ready);

    assign w_if_cand = if_req_valid && w_if_elig;
    assign w_ld_cand = ld_req_valid && w_ld_elig;

    always_comb begin
        w_gnt_if = 1'b0;
        w_gnt_ld = 1'b0;
        if (w_if_cand && w_ld_cand) begin
            if (r_rr_last == PORT_LD) begin
                w_gnt_if = 1'b1;
            end else begin
                w_gnt_ld = 1'b1;
            end
        end else begin
            w_gnt_if = w_if_cand;
            w_gnt_ld = w_ld_cand;
        end
    end

    assign if_req_ready = w_gnt_if;
    assign ld_req_ready = w_gnt_ld;

    always_comb begin
        mem_addr = r_hold;
        if (w_gnt_if) begin
            mem_addr = w_if_word;
        end else if (w_gnt_ld) begin
            mem_addr = w_ld_word;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_infl    <= '0;
            r_rr_last <= PORT_LD;
            r_hold    <= '0;
        end else begin
            r_infl.valid <= w_gnt_if || w_gnt_ld;
            r_infl.tag   <= w_gnt_ld ? PORT_LD : PORT_IF;
            if (w_gnt_if || w_gnt_ld) begin
                r_rr_last <= w_gnt_ld ? PORT_LD : PORT_IF;
                r_hold    <= mem_addr;
            end
        end
    end

    // A flush during the landing cycle kills the in-flight fetch word.
    assign w_if_wr = w_if_infl && !if_flush;
    assign w_ld_wr = w_ld_infl;

    imem_port_arbiter_rsp_slot #(
        .DATA_W (DATA_W)
    ) u_if_slot (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_wr    (w_if_wr),
        .i_wdata (mem_rdata),
        .i_rd    (if_rsp_ready),
        .i_clr   (if_flush),
        .o_valid (if_rsp_valid),
        .o_data  (if_rsp_data)
    );

    imem_port_arbiter_rsp_slot #(
        .DATA_W (DATA_W)
    ) u_ld_slot (
        .i_clk   (iCLK),
        .i_rst   (iRST),
        .i_wr    (w_ld_wr),
        .i_wdata (mem_rdata),
        .i_rd    (ld_rsp_ready),
        .i_clr   (1'b0),
        .o_valid (ld_rsp_valid),
        .o_data  (ld_rsp_data)
    );

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single-port instruction/data ROM between the fetch unit (IF port) and the load unit (LD port).
- The ROM registers its address on the iCLK edge and drives data combinationally in the following cycle.
- Grants one request per cycle with round-robin fairness, tracks the single in-flight read, and steers read data into a 1-entry response buffer per port with valid/ready backpressure.
- Supports a fetch flush that drops stale instruction reads after a taken branch.

Parameters:
ADDR_W, 32, requester byte-address width
DATA_W, 32, ROM word width
MEM_AW, 8, ROM word-address width (256 words)

Ports:
iCLK  in  1  clock, all state on rising edge
iRST  in  1  asynchronous active-high reset
if_req_valid  in  1  fetch request present
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  ADDR_W  fetch byte address
if_rsp_valid  out  1  fetch response buffer full
if_rsp_ready  in  1  fetch consumer takes response
if_rsp_data  out  DATA_W  fetch response word
if_flush  in  1  discard in-flight/buffered fetch data
ld_req_valid  in  1  load request present
ld_req_ready  out  1  load request accepted this cycle
ld_req_addr  in  ADDR_W  load byte address
ld_rsp_valid  out  1  load response buffer full
ld_rsp_ready  in  1  load consumer takes response
ld_rsp_data  out  DATA_W  load response word
mem_addr  out  MEM_AW  ROM word address (to ROM address register)
mem_rdata  in  DATA_W  ROM data, valid the cycle after address capture

Behaviour:
- **Reset (async, iRST=1):**
  - if_rsp_valid=0, ld_rsp_valid=0.
  - req_ready outputs are 0 while iRST=1.
  - Response buffer data=0; mem_addr=0.
  - In-flight flag=0; rr_last=LD, so IF wins the first tie.
  - Reset mid-transfer drops the in-flight read and any buffered responses.
- **Word address:** mem_addr = req_addr[MEM_AW+1:2] of the granted port. Bits [1:0] and bits above MEM_AW+1 are ignored. No alignment error is raised.
- **Eligibility per port p:**
  - p is eligible when its response slot will be free when the data lands.
  - Condition: NOT inflight_p AND (NOT rsp_valid_p OR rsp_ready_p).
  - This prevents the buffer from ever being overwritten.
- **Grant:**
  - If one port is valid and eligible, it is granted.
  - If both are valid and eligible, the port other than rr_last is granted and rr_last is updated.
  - The grant is combinational in the same cycle: req_ready_p=1 only for the granted port.
  - A request is accepted when req_valid AND req_ready; the requester may change its address after acceptance.
- **mem_addr when idle:** holds the last granted word address (hold register), so the ROM output stays stable.
- **Pipeline:**
  - Cycle N: accept; mem_addr driven; ROM captures at the end of N.
  - Cycle N+1: inflight tag = p; mem_rdata written into buffer p at the end of N+1.
  - Cycle N+2: rsp_valid_p=1.
  - Latency is 2 cycles from accept to rsp_valid.
  - Back-to-back grants to alternating ports sustain 1 read per cycle. A single port sustains 1 read per 2 cycles.
- **Response handshake:**
  - rsp_valid_p stays high, with data stable, until rsp_ready_p is seen high.
  - rsp_ready while rsp_valid=0 is ignored.
  - Drain and refill of the same buffer in one cycle is allowed (valid stays 1, data updates).
- **if_flush=1 in cycle N:**
  - Clears if_rsp_valid at the end of N.
  - Marks any in-flight IF read as killed, so its data is not written.
  - Forces if_req_ready=0 in N.
  - LD traffic is unaffected; an LD grant in N proceeds normally.
- **Simultaneous flush and if_rsp_ready:** flush wins; the buffer is simply cleared.
- **Invariant:** at most one read is in flight (1-bit valid plus 1-bit port tag plus kill bit).

Decomposition:
- Shared package holds:
  - the port index constants PORT_IF=0 and PORT_LD=1;
  - the default widths;
  - a helper function for byte-to-word address conversion.
- Natural sub-module: rsp_slot, one 1-entry valid/ready buffer with write, drain and clear. It is instantiated twice.
- Grant logic and in-flight tracking stay in the top level.

Test Plan:
1. ROM preloaded with mem[k]=0xA000_0000+k; IF requests addr 0x10 with rsp_ready=1 -> if_req_ready=1 in cycle 0; if_rsp_valid=1 with data 0xA000_0004 in cycle 2.
2. IF and LD both valid every cycle after reset, IF addr 0x0, LD addr 0x40 -> grants alternate IF, LD, IF, LD; IF receives 0xA000_0000 and LD receives 0xA000_0010, one response per cycle in steady state.
3. IF request at addr 0x8 accepted, if_rsp_ready held 0 -> if_rsp_valid stays 1 with 0xA000_0002; further IF requests get if_req_ready=0 until rsp_ready pulses, and the data is not overwritten.
4. IF request accepted in cycle 0, if_flush=1 in cycle 1 -> no if_rsp_valid in cycles 2-3; an IF request in cycle 2 is accepted and returns valid data in cycle 4.
5. LD accepted in cycle 0, if_flush in cycle 1 -> ld_rsp_valid=1 in cycle 2 with the correct word; LD is unaffected.
6. iRST asserted in cycle 1 with a read in flight and a full LD buffer -> all rsp_valid=0 immediately; after release, the first tie is granted to IF.
